div_result_bcd: RTL and testbench

DIV_RESULT_BCD -- requirements
Module: div_result_bcd

---
 rtl/div_pkg.sv | 29 ++
 rtl/bcd_dd_engine.sv | 46 ++++
 rtl/div_result_bcd.sv | 118 +++++++++++
 tb/tb_div_result_bcd.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divider-result BCD converter.
//   state_t    : converter FSM states
//   bcd_digits : number of decimal digits needed for an unsigned value of a given width
//   ERR_DIGIT  : digit code emitted for a divide-by-zero result
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] ERR_DIGIT = 4'hE;

  // Digits needed to print 2^width-1 in decimal; equals ceil(width*log10(2)).
  function automatic int bcd_digits(input int width);
    longint v;
    int     n;
    v = (longint'(1) << width) - 1;
    n = 0;
    while (v > 0) begin
      n++;
      v = v / 10;
    end
    if (n == 0) n = 1;
    return n;
  endfunction

endpackage

// File: rtl/bcd_dd_engine.sv
// Double-dabble engine for one operand.
//   clk     : clock
//   rst     : synchronous active-high reset (clears shift register and digits)
//   load    : capture operand, clear the BCD accumulator
//   step    : one double-dabble step (adjust digits >=5 by +3, then shift in operand MSB)
//   operand : binary value to convert
//   bcd     : packed BCD accumulator, most significant digit in the top nibble
module bcd_dd_engine #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [WIDTH-1:0]      operand,
  output logic [4*DIGITS-1:0]   bcd
);

  logic [WIDTH-1:0]    sh_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] adj;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      bcd_q <= '0;
    end else if (load) begin
      sh_q  <= operand;
      bcd_q <= '0;
    end else if (step) begin
      sh_q  <= sh_q << 1;
      bcd_q <= {adj[4*DIGITS-2:0], sh_q[WIDTH-1]};
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/div_result_bcd.sv
// Converts an unsigned divider result (quotient, remainder) into packed BCD.
// Both operands are converted in parallel, one double-dabble step per cycle.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake for quotient/remainder
//   out_valid / out_ready: output handshake for q_bcd/r_bcd
//   busy                 : high whenever not IDLE
// Optional feature, macro DIV_RESULT_BCD_DIV0_EN: adds div_by_zero input and
// out_err output; a flagged result skips conversion and emits all-0xE digits.
//
// state | meaning
// IDLE  | waiting for a result, in_ready high
// CONV  | running WIDTH double-dabble steps (or one cycle for a div-by-zero result)
// DONE  | BCD result held, out_valid high until consumed
module div_result_bcd
  import div_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = bcd_digits(WIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    quotient,
  input  logic [WIDTH-1:0]    remainder,
`ifdef DIV_RESULT_BCD_DIV0_EN
  input  logic                div_by_zero,
  output logic                out_err,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] q_bcd,
  output logic [4*DIGITS-1:0] r_bcd,
  output logic                busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               load;
  logic               step;
  logic               err_q;
  logic [4*DIGITS-1:0] q_eng, r_eng;

`ifdef DIV_RESULT_BCD_DIV0_EN
  always_ff @(posedge clk) begin
    if (rst)       err_q <= 1'b0;
    else if (load) err_q <= div_by_zero;
  end
  assign out_err = err_q && (state_q == DONE);
`else
  assign err_q = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        // A div-by-zero result bypasses the steps and finishes one cycle after accept.
        if (err_q) begin
          state_d = DONE;
        end else begin
          step = 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load)      cnt_q <= '0;
      else if (step) cnt_q <= cnt_q + 1'b1;
    end
  end

  bcd_dd_engine #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_q_eng (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .operand (quotient),
    .bcd     (q_eng)
  );

  bcd_dd_engine #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_r_eng (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .operand (remainder),
    .bcd     (r_eng)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign q_bcd     = err_q ? {DIGITS{ERR_DIGIT}} : q_eng;
  assign r_bcd     = err_q ? {DIGITS{ERR_DIGIT}} : r_eng;

endmodule

// File: tb/tb_div_result_bcd.sv
// Self-checking bench for div_result_bcd (WIDTH=8, DIGITS=3).
// Reference BCD is computed with plain decimal arithmetic.
// Define DIV_RESULT_BCD_DIV0_EN to also exercise the divide-by-zero path.
module tb_div_result_bcd;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    quotient;
  logic [WIDTH-1:0]    remainder;
  logic                out_valid;
  logic                out_ready;
  logic [4*DIGITS-1:0] q_bcd;
  logic [4*DIGITS-1:0] r_bcd;
  logic                busy;
`ifdef DIV_RESULT_BCD_DIV0_EN
  logic                div_by_zero;
  logic                out_err;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  div_result_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .quotient    (quotient),
    .remainder   (remainder),
`ifdef DIV_RESULT_BCD_DIV0_EN
    .div_by_zero (div_by_zero),
    .out_err     (out_err),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .q_bcd       (q_bcd),
    .r_bcd       (r_bcd),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    logic [11:0] res;
    res = '0;
    for (int i = 0; i < DIGITS; i++) begin
      res[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return res;
  endfunction

  // One transaction: accept, wait for out_valid, stall the consumer, handshake.
  // garble keeps in_valid high with junk operands while busy (must be ignored).
  task automatic run_one(input int q, input int r, input bit dz, input int stall, input bit garble);
    int          lat;
    int          exp_lat;
    logic [11:0] eq, er;
    @(negedge clk);
    quotient  = WIDTH'(q);
    remainder = WIDTH'(r);
    in_valid  = 1'b1;
`ifdef DIV_RESULT_BCD_DIV0_EN
    div_by_zero = dz;
`endif
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    if (garble) begin
      quotient  = WIDTH'($urandom);
      remainder = WIDTH'($urandom);
`ifdef DIV_RESULT_BCD_DIV0_EN
      div_by_zero = 1'b0;
`endif
    end else begin
      in_valid = 1'b0;
    end
    check("busy_after_accept", busy, 1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      check("in_ready_while_conv", in_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    exp_lat = dz ? 1 : WIDTH;
    eq = dz ? 12'hEEE : ref_bcd(q);
    er = dz ? 12'hEEE : ref_bcd(r);
    check("latency", lat, exp_lat);
    check("q_bcd", q_bcd, eq);
    check("r_bcd", r_bcd, er);
`ifdef DIV_RESULT_BCD_DIV0_EN
    check("out_err", out_err, dz);
`endif
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_q", q_bcd, eq);
      check("hold_r", r_bcd, er);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_busy", busy, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    quotient  = '0;
    remainder = '0;
`ifdef DIV_RESULT_BCD_DIV0_EN
    div_by_zero = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_q", q_bcd, 0);
    check("rst_r", r_bcd, 0);
    rst = 1'b0;

    run_one(255, 7, 1'b0, 0, 1'b0);
    run_one(0, 0, 1'b0, 0, 1'b0);
    run_one(99, 10, 1'b0, 5, 1'b0);

    // Reset mid-conversion aborts the result.
    @(negedge clk);
    quotient = 8'd200; remainder = 8'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_q", q_bcd, 0);
    check("abort_r", r_bcd, 0);
    repeat (12) begin
      @(posedge clk); #1;
      check("abort_no_emit", out_valid, 0);
    end
    run_one(128, 3, 1'b0, 0, 1'b0);

    // Exhaustive quotient sweep with random remainders.
    for (int q = 0; q < 256; q++) begin
      run_one(q, int'($urandom_range(255, 0)), 1'b0, 0, 1'b0);
    end

    // Random transactions with random stalls and ignored upstream traffic.
    for (int k = 0; k < 40; k++) begin
      run_one(int'($urandom_range(255, 0)), int'($urandom_range(255, 0)), 1'b0,
              int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
    end

`ifdef DIV_RESULT_BCD_DIV0_EN
    run_one(37, 5, 1'b1, 2, 1'b0);
    run_one(200, 100, 1'b0, 0, 1'b0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
